jt51_wrfifo: RTL
================

JT51_WRFIFO -- requirements
Module: jt51_wrfifo

Interface
REQ-001 SHALL have parameter DEPTH, 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter BUSY_TO, 4, clk cycles to wait for busy to rise before proceeding.
REQ-003 SHALL have port clk  input  1  main clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port push  input  1  host request to queue one register write.
REQ-006 SHALL have port push_addr  input  8  YM2151 register address.
REQ-007 SHALL have port push_data  input  8  register data.
REQ-008 SHALL have port ovf_clr  input  1  clears ovf.
REQ-009 SHALL have port busy  input  1  chip busy flag (d_out bit 7 of the synth core).
REQ-010 SHALL have port cs_n, wr_n, a0  output  1 each  chip write strobes.
REQ-011 SHALL have port dout  output  8  chip data bus.
REQ-012 SHALL have ports full, empty, idle, ovf  output  1 each, and level  output  log2(DEPTH)+1  occupancy.

Function
REQ-013 SHALL store {addr,data} pairs first-in first-out; level = entries held, excluding the one being issued.
REQ-014 SHALL accept push when not full, or when full and a pop occurs the same cycle; otherwise drop it and set ovf (sticky).
REQ-015 SHALL clear ovf on ovf_clr; a simultaneous drop and ovf_clr leaves ovf=1.
REQ-016 SHALL run FSM IDLE, AWR, ASEEN, AWAIT, DWR, DSEEN, DWAIT.
REQ-017 IDLE: when not empty and busy=0, pop head into issue register and go to AWR (DWR when the address-skip in REQ-028 applies).
REQ-018 AWR: exactly one cycle with cs_n=0, wr_n=0, a0=0, dout=addr; then ASEEN.
REQ-019 ASEEN: go to AWAIT when busy=1, or after BUSY_TO cycles without busy.
REQ-020 AWAIT: stay while busy=1; go to DWR on busy=0.
REQ-021 DWR/DSEEN/DWAIT: same as AWR/ASEEN/AWAIT with a0=1, dout=data; DWAIT exits to IDLE.
REQ-022 Outside AWR/DWR: cs_n=1, wr_n=1; a0 and dout hold their last driven values.
REQ-023 Pushes during issue do not disturb the entry in flight.
REQ-024 idle=1 only in IDLE with empty=1.
REQ-025 Minimum cost per entry with busy one cycle wide: 6 cycles (both phases).

Reset
REQ-026 On rst: FSM=IDLE, FIFO emptied (level=0, empty=1, full=0), ovf=0, cs_n=1, wr_n=1, a0=0, dout=0, idle=1; immediate, asynchronous.
REQ-027 Reset mid-issue SHALL abandon the entry, with no further strobe after rst deasserts.

Configuration
REQ-028 With JT51_WRFIFO_ADDR_CACHE_EN defined, SHALL hold the last issued address plus a valid bit, and when a popped address equals it and valid=1, skip the AWR/ASEEN/AWAIT phases.
REQ-029 With JT51_WRFIFO_ADDR_CACHE_EN defined, SHALL clear the valid bit on reset.
REQ-030 Without the macro, every entry issues both phases, and no cache registers exist.

Structure
REQ-031 Package jt51_wrfifo_pkg SHALL hold the FSM state type and the default DEPTH/BUSY_TO constants.
REQ-032 Storage and pointers SHALL be in sub-module jt51_wrfifo_mem (push/pop, full/empty/level); jt51_wrfifo holds the FSM and strobes.

Verification
REQ-033 Push (0x20,0xC7), busy pulses 1 cycle after each strobe -> AWR a0=0 dout=0x20, then DWR a0=1 dout=0xC7, idle=1 afterwards.
REQ-034 DEPTH=16: 17 pushes with busy held 1 -> full=1, level=16, ovf=1, 17th dropped; release busy -> 16 entries issued in order.
REQ-035 Busy never rises -> each phase proceeds after BUSY_TO=4 cycles; entry completes in 12 cycles.
REQ-036 Assert rst during DWAIT with 3 queued -> empty=1, level=0, no strobe after release.
REQ-037 With JT51_WRFIFO_ADDR_CACHE_EN: push (0x08,0x01), (0x08,0x02) -> second entry produces only the a0=1 strobe; without the macro -> two a0=0 strobes.
REQ-038 Full FIFO, push and pop in same cycle -> accepted, level unchanged, ovf=0.

Source files
------------

// File: rtl/jt51_wrfifo_pkg.sv
// jt51_wrfifo_pkg: shared FSM state type, default sizing constants and a small helper
// for the JT51 register-write FIFO.
//   DEF_DEPTH   : default number of FIFO entries
//   DEF_BUSY_TO : default cycles to wait for the chip busy flag to rise
//   state_t     : issue FSM states
//   is_strobe() : true in the states that drive a write strobe to the chip
package jt51_wrfifo_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_BUSY_TO = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AWR,
        S_ASEEN,
        S_AWAIT,
        S_DWR,
        S_DSEEN,
        S_DWAIT
    } state_t;

    function automatic logic is_strobe(input state_t s);
        return (s == S_AWR) || (s == S_DWR);
    endfunction

endpackage

// File: rtl/jt51_wrfifo_mem.sv
// jt51_wrfifo_mem: circular storage for {addr,data} register writes with occupancy flags.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write request; taken when not full, or when full with i_pop the same cycle
//   i_din      : {addr[7:0], data[7:0]} to store
//   i_pop      : remove the head entry (caller only pops when not empty)
//   o_dout     : head entry, valid while o_empty = 0
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_level    : number of entries held
//   o_acc      : the push in this cycle is accepted
module jt51_wrfifo_mem
    import jt51_wrfifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [15:0]              i_din,
    input  logic                     i_pop,
    output logic [15:0]              o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_acc
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0] r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign o_level = r_wp - r_rp;
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign o_acc   = i_push && (!o_full || i_pop);
    assign o_dout  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (o_acc)
                r_wp <= r_wp + 1'b1;
            if (i_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (o_acc)
            r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/jt51_wrfifo.sv
// jt51_wrfifo: queues YM2151 register writes and replays them to the chip, pacing each
// address/data phase on the chip busy flag.
//   clk, rst          : clock, asynchronous active-high reset (abandons any write in flight)
//   push, push_addr,
//   push_data         : host request to queue one {addr,data} register write
//   ovf_clr           : clears the sticky overflow flag
//   busy              : chip busy flag
//   cs_n, wr_n, a0,
//   dout              : chip write bus; a0 and dout hold their last driven values
//   full, empty,
//   level             : FIFO occupancy, excluding the entry being issued
//   idle              : nothing queued and nothing in flight
//   ovf               : a push was dropped because the FIFO was full
// Optional feature: JT51_WRFIFO_ADDR_CACHE_EN remembers the last issued address and
// skips the address phase when the next entry targets the same register.
module jt51_wrfifo
    import jt51_wrfifo_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BUSY_TO = DEF_BUSY_TO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_addr,
    input  logic [7:0]               push_data,
    input  logic                     ovf_clr,
    input  logic                     busy,
    output logic                     cs_n,
    output logic                     wr_n,
    output logic                     a0,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic                     idle,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = $clog2(BUSY_TO + 1);

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_issue;
    logic          r_strb_n;
    logic          r_a0;
    logic [7:0]    r_dout;
    logic          r_ovf;
    logic [15:0]   w_head;
    logic [15:0]   w_entry;
    logic          w_pop;
    logic          w_acc;
    logic          w_to;
    logic          w_hit;

    jt51_wrfifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_push  (push),
        .i_din   ({push_addr, push_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level),
        .o_acc   (w_acc)
    );

    assign w_pop   = (r_state == S_IDLE) && !empty && !busy;
    // In IDLE the entry being launched is still at the FIFO head; afterwards it lives in r_issue.
    assign w_entry = (r_state == S_IDLE) ? w_head : r_issue;
    assign w_to    = (r_cnt == CW'(BUSY_TO - 1));

`ifdef JT51_WRFIFO_ADDR_CACHE_EN
    logic [7:0] r_last;
    logic       r_last_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= '0;
            r_last_v <= 1'b0;
        end else if (w_nxt == S_AWR) begin
            r_last   <= w_entry[15:8];
            r_last_v <= 1'b1;
        end
    end

    assign w_hit = r_last_v && (w_head[15:8] == r_last);
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_nxt = w_hit ? S_DWR : S_AWR;
            S_AWR:   w_nxt = S_ASEEN;
            S_ASEEN: if (busy || w_to) w_nxt = S_AWAIT;
            S_AWAIT: if (!busy) w_nxt = S_DWR;
            S_DWR:   w_nxt = S_DSEEN;
            S_DSEEN: if (busy || w_to) w_nxt = S_DWAIT;
            S_DWAIT: if (!busy) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each strobe lines up with the
    // single cycle spent in AWR or DWR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_issue  <= '0;
            r_strb_n <= 1'b1;
            r_a0     <= 1'b0;
            r_dout   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_cnt    <= (r_state == S_ASEEN || r_state == S_DSEEN) ? r_cnt + 1'b1 : '0;
            r_strb_n <= !is_strobe(w_nxt);
            r_ovf    <= (push && !w_acc) ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
            if (w_pop)
                r_issue <= w_head;
            if (w_nxt == S_AWR) begin
                r_a0   <= 1'b0;
                r_dout <= w_entry[15:8];
            end
            if (w_nxt == S_DWR) begin
                r_a0   <= 1'b1;
                r_dout <= w_entry[7:0];
            end
        end
    end

    assign cs_n = r_strb_n;
    assign wr_n = r_strb_n;
    assign a0   = r_a0;
    assign dout = r_dout;
    assign ovf  = r_ovf;
    assign idle = (r_state == S_IDLE) && empty;

endmodule
